// File: rtl/uart_pkg.sv
// Shared types, constants and the parity helper used by the configurable UART core.
package uart_pkg;

    localparam int SB_TICK_DEF = 16;
    localparam int HALF_TICK   = SB_TICK_DEF / 2;
    localparam int STOP2_TICKS = 2 * SB_TICK_DEF;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Data is zero-extended to 9 bits, so narrower words reduce correctly.
    function automatic logic parity_bit(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only alongside a pop.
module fifo #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_SPACE_EXP = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  empty,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] r_data
);

    localparam int DEPTH = 2 ** ADDR_SPACE_EXP;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [ADDR_SPACE_EXP-1:0] wptr_q, rptr_q;
    logic [ADDR_SPACE_EXP:0]   cnt_q;
    logic do_rd, do_wr;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == (ADDR_SPACE_EXP+1)'(DEPTH));
    assign do_rd  = rd & ~empty;
    assign do_wr  = wr & (~full | do_rd);
    assign r_data = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= w_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_par.sv
// Receive path: 2-flop synchroniser, oversampled RX FSM, parity and framing checks.
module uart_rx_par
    import uart_pkg::*;
#(
    parameter int DBITS   = 8,
    parameter int SB_TICK = SB_TICK_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             rx_i,
    input  logic             parity_en_i,
    input  logic             parity_odd_i,
    output logic             push_o,
    output logic [DBITS-1:0] data_o,
    output logic             par_err_o,
    output logic             frm_err_o
);

    localparam int SW   = $clog2(SB_TICK);
    localparam int HALF = SB_TICK / 2;

    rx_state_t        state_q, state_d;
    logic [1:0]       sync_q;
    logic [SW-1:0]    s_q, s_d;
    logic [3:0]       n_q, n_d;
    logic [DBITS-1:0] b_q, b_d;
    logic             pen_q, pen_d, odd_q, odd_d, perr_q, perr_d;
    logic             rx_s;

    assign rx_s   = sync_q[1];
    assign data_o = b_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RX_IDLE;
            sync_q  <= 2'b11;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            pen_q   <= 1'b0;
            odd_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rx_i};
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            pen_q   <= pen_d;
            odd_q   <= odd_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        b_d       = b_q;
        pen_d     = pen_q;
        odd_d     = odd_q;
        perr_d    = perr_q;
        push_o    = 1'b0;
        par_err_o = 1'b0;
        frm_err_o = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    s_d     = '0;
                    pen_d   = parity_en_i;
                    odd_d   = parity_odd_i;
                    perr_d  = 1'b0;
                end
            end
            RX_START: begin
                if (tick_i) begin
                    if (s_q == SW'(HALF - 1)) begin
                        // A line that is high again at mid-start was only a glitch.
                        state_d = rx_s ? RX_IDLE : RX_DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (tick_i) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBITS-1:1]};
                        if (n_q == 4'(DBITS - 1)) state_d = pen_q ? RX_PARITY : RX_STOP;
                        else                      n_d = n_q + 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (tick_i) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        s_d     = '0;
                        perr_d  = rx_s ^ parity_bit(9'(b_q), odd_q);
                        state_d = RX_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (tick_i) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d   = RX_IDLE;
                        push_o    = rx_s;
                        frm_err_o = ~rx_s;
                        par_err_o = perr_q;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_core_cfg.sv
// Full-duplex UART with runtime baud divisor and frame format, FIFOs and sticky errors.
// Define UART_LOOPBACK_EN to add a loopback input routing tx back into the receiver.
module uart_core_cfg
    import uart_pkg::*;
#(
    parameter int DBITS    = 8,
    parameter int SB_TICK  = SB_TICK_DEF,
    parameter int BR_BITS  = 11,
    parameter int FIFO_EXP = 4
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic [BR_BITS-1:0] baud_div,
    input  logic               parity_en,
    input  logic               parity_odd,
    input  logic               two_stop,
    input  logic               write_uart,
    input  logic [DBITS-1:0]   write_data,
    output logic               tx_full,
    input  logic               read_uart,
    output logic [DBITS-1:0]   read_data,
    output logic               rx_empty,
    output logic               rx_full,
    input  logic               err_clear,
    output logic               overrun_err,
    output logic               parity_err,
    output logic               framing_err,
    output logic               tx_busy,
`ifdef UART_LOOPBACK_EN
    input  logic               loopback,
`endif
    input  logic               rx,
    output logic               tx
);

    localparam int STOP2 = 2 * SB_TICK;
    localparam int SW    = $clog2(STOP2);

    logic [BR_BITS-1:0] cnt_q, cnt_d;
    logic               tick;

    tx_state_t        state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [3:0]       n_q, n_d;
    logic [DBITS-1:0] b_q, b_d;
    logic             par_q, par_d, pen_q, pen_d, ts_q, ts_d, tx_q, tx_d;
    logic             tx_pop, tx_empty;
    logic [DBITS-1:0] tx_head;

    logic             rx_src, rx_push, rx_par_err, rx_frm_err;
    logic [DBITS-1:0] rx_word;
    logic             ovr_q, par_err_q, frm_err_q;

    // Counter above a freshly lowered divisor runs on to all-ones before wrapping.
    assign tick  = (cnt_q == baud_div);
    assign cnt_d = tick ? '0 : cnt_q + BR_BITS'(1);

`ifdef UART_LOOPBACK_EN
    assign rx_src = loopback ? tx_q : rx;
    assign tx     = loopback ? 1'b1 : tx_q;
`else
    assign rx_src = rx;
    assign tx     = tx_q;
`endif

    assign tx_busy = (state_q != TX_IDLE);

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            state_q <= TX_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            par_q   <= 1'b0;
            pen_q   <= 1'b0;
            ts_q    <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            par_q   <= par_d;
            pen_q   <= pen_d;
            ts_q    <= ts_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        par_d   = par_q;
        pen_d   = pen_q;
        ts_d    = ts_q;
        tx_pop  = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    state_d = TX_START;
                    s_d     = '0;
                    n_d     = '0;
                    b_d     = tx_head;
                    par_d   = parity_bit(9'(tx_head), parity_odd);
                    pen_d   = parity_en;
                    ts_d    = two_stop;
                end
            end
            TX_START: begin
                if (tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d = TX_DATA;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == 4'(DBITS - 1)) state_d = pen_q ? TX_PARITY : TX_STOP;
                        else                      n_d = n_q + 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d = TX_STOP;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (s_q == (ts_q ? SW'(STOP2 - 1) : SW'(SB_TICK - 1))) begin
                        state_d = TX_IDLE;
                        tx_pop  = 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Line level follows the next state so tx and the state register change together.
        unique case (state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = b_d[0];
            TX_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    fifo #(.DATA_WIDTH(DBITS), .ADDR_SPACE_EXP(FIFO_EXP)) u_tx_fifo (
        .clk    (clk_100MHz),
        .reset  (reset),
        .rd     (tx_pop),
        .wr     (write_uart),
        .w_data (write_data),
        .empty  (tx_empty),
        .full   (tx_full),
        .r_data (tx_head)
    );

    uart_rx_par #(.DBITS(DBITS), .SB_TICK(SB_TICK)) u_rx (
        .clk_i        (clk_100MHz),
        .rst_ni       (reset),
        .tick_i       (tick),
        .rx_i         (rx_src),
        .parity_en_i  (parity_en),
        .parity_odd_i (parity_odd),
        .push_o       (rx_push),
        .data_o       (rx_word),
        .par_err_o    (rx_par_err),
        .frm_err_o    (rx_frm_err)
    );

    fifo #(.DATA_WIDTH(DBITS), .ADDR_SPACE_EXP(FIFO_EXP)) u_rx_fifo (
        .clk    (clk_100MHz),
        .reset  (reset),
        .rd     (read_uart),
        .wr     (rx_push),
        .w_data (rx_word),
        .empty  (rx_empty),
        .full   (rx_full),
        .r_data (read_data)
    );

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            ovr_q     <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            ovr_q     <= (rx_push & rx_full & ~read_uart) | (ovr_q & ~err_clear);
            par_err_q <= rx_par_err | (par_err_q & ~err_clear);
            frm_err_q <= rx_frm_err | (frm_err_q & ~err_clear);
        end
    end

    assign overrun_err = ovr_q;
    assign parity_err  = par_err_q;
    assign framing_err = frm_err_q;

endmodule

// File: tb/tb_uart_core_cfg.sv
// Scoreboard bench for uart_core_cfg: TX bit queue checked on the line, RX word queue checked on readout.
module tb_uart_core_cfg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] baud_div;
    logic        parity_en, parity_odd, two_stop;
    logic        write_uart, read_uart, err_clear;
    logic [7:0]  write_data, read_data;
    logic        tx_full, rx_empty, rx_full;
    logic        overrun_err, parity_err, framing_err, tx_busy, tx;
    logic        rx_drv, loop_mode;
    wire         rx_w;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] rx_exp_q [$];
    logic       tx_bit_q [$];

    always #5 clk = ~clk;
    assign rx_w = loop_mode ? tx : rx_drv;

    uart_core_cfg dut (
        .clk_100MHz  (clk),
        .reset       (reset_n),
        .baud_div    (baud_div),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .two_stop    (two_stop),
        .write_uart  (write_uart),
        .write_data  (write_data),
        .tx_full     (tx_full),
        .read_uart   (read_uart),
        .read_data   (read_data),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full),
        .err_clear   (err_clear),
        .overrun_err (overrun_err),
        .parity_err  (parity_err),
        .framing_err (framing_err),
        .tx_busy     (tx_busy),
`ifdef UART_LOOPBACK_EN
        .loopback    (1'b0),
`endif
        .rx          (rx_w),
        .tx          (tx)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int bp();
        return 16 * (int'(baud_div) + 1);
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_word(input logic [7:0] d);
        write_data = d;
        write_uart = 1'b1;
        @(negedge clk);
        write_uart = 1'b0;
    endtask

    task automatic queue_tx_frame(input logic [7:0] d, input bit pen, input bit odd, input int nstop);
        logic p;
        p = (^d) ^ odd;
        tx_bit_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_bit_q.push_back(d[i]);
        if (pen) tx_bit_q.push_back(p);
        for (int i = 0; i < nstop; i++) tx_bit_q.push_back(1'b1);
    endtask

    task automatic check_tx_frame();
        bit seen = 1'b0;
        int nb;
        for (int i = 0; i < 3000; i++) begin
            if (tx === 1'b0) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check_val("tx_start_seen", seen, 1);
        if (!seen) begin tx_bit_q.delete(); return; end
        nb = tx_bit_q.size();
        cycles(bp() / 2);
        for (int k = 0; k < nb; k++) begin
            check_val($sformatf("tx_bit%0d", k), tx, tx_bit_q.pop_front());
            if (k != nb - 1) cycles(bp());
        end
    endtask

    task automatic measure_busy(output int len);
        len = 0;
        for (int i = 0; i < 3000 && tx_busy !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 3000 && tx_busy === 1'b1; i++) begin len++; @(negedge clk); end
    endtask

    task automatic measure_start(output int len);
        len = 0;
        for (int i = 0; i < 3000 && tx !== 1'b0; i++) @(negedge clk);
        for (int i = 0; i < 3000 && tx === 1'b0; i++) begin len++; @(negedge clk); end
    endtask

    task automatic send_rx(input logic [7:0] d, input bit pen, input logic pbit, input bit bad_stop);
        int b;
        b = bp();
        rx_drv = 1'b0; cycles(b);
        for (int i = 0; i < 8; i++) begin rx_drv = d[i]; cycles(b); end
        if (pen) begin rx_drv = pbit; cycles(b); end
        if (bad_stop) begin
            rx_drv = 1'b0; cycles(b * 3 / 4);
            rx_drv = 1'b1; cycles(b / 4);
        end else begin
            rx_drv = 1'b1; cycles(b);
        end
        cycles(b);
    endtask

    task automatic read_check();
        logic [7:0] exp;
        check_val("rx_sb_nonempty", rx_exp_q.size() != 0, 1);
        if (rx_exp_q.size() == 0) return;
        exp = rx_exp_q.pop_front();
        check_val("rx_avail", rx_empty, 0);
        check_val("rx_data", read_data, exp);
        read_uart = 1'b1;
        @(negedge clk);
        read_uart = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy_len, start_len;
        logic [7:0] d;

        reset_n = 1'b0; baud_div = 11'd3;
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        write_uart = 1'b0; write_data = '0; read_uart = 1'b0; err_clear = 1'b0;
        rx_drv = 1'b1; loop_mode = 1'b0;
        cycles(3);
        check_val("rst_tx", tx, 1);
        check_val("rst_tx_busy", tx_busy, 0);
        check_val("rst_rx_empty", rx_empty, 1);
        check_val("rst_rx_full", rx_full, 0);
        check_val("rst_tx_full", tx_full, 0);
        check_val("rst_flags", {overrun_err, parity_err, framing_err}, 0);
        reset_n = 1'b1;
        cycles(2);

        // 8N1 0xA5 at baud_div 3: 64 clocks per bit
        queue_tx_frame(8'hA5, 0, 0, 1);
        write_word(8'hA5);
        fork
            check_tx_frame();
            measure_busy(busy_len);
            measure_start(start_len);
        join
        check_val("a5_busy_len_ok", (busy_len >= 636 && busy_len <= 641), 1);
        check_val("a5_start_len_ok", (start_len >= 60 && start_len <= 65), 1);
        cycles(200);
        check_val("a5_single_pop", tx_busy, 0);
        check_val("a5_rx_idle", rx_empty, 1);

        // 8E2 through tx->rx external loop
        loop_mode = 1'b1; parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b1;
        cycles(2);
        rx_exp_q.push_back(8'h3C); rx_exp_q.push_back(8'h81); rx_exp_q.push_back(8'hFF);
        write_word(8'h3C); write_word(8'h81); write_word(8'hFF);
        measure_busy(busy_len);
        check_val("e2_frame_len_ok", (busy_len >= 764 && busy_len <= 769), 1);
        cycles(3 * 768);
        check_val("e2_tx_idle", tx_busy, 0);
        for (int i = 0; i < 3; i++) read_check();
        check_val("e2_rx_drained", rx_empty, 1);
        check_val("e2_flags", {overrun_err, parity_err, framing_err}, 0);
        loop_mode = 1'b0;
        cycles(2);

        // odd parity: good frame, then bad parity on 0x55
        parity_en = 1'b1; parity_odd = 1'b1; two_stop = 1'b0;
        d = 8'h0F;
        rx_exp_q.push_back(d);
        send_rx(d, 1, (^d) ^ 1'b1, 0);
        check_val("par_ok_no_err", parity_err, 0);
        read_check();
        d = 8'h55;
        rx_exp_q.push_back(d);
        send_rx(d, 1, ~((^d) ^ 1'b1), 0);
        check_val("par_bad_err", parity_err, 1);
        check_val("par_bad_frm", framing_err, 0);
        read_check();
        check_val("par_err_sticky", parity_err, 1);
        pulse_clear();
        check_val("par_err_cleared", parity_err, 0);

        // 0x12 with a low stop bit is discarded
        parity_en = 1'b0;
        send_rx(8'h12, 0, 1'b0, 1);
        check_val("frm_err_set", framing_err, 1);
        check_val("frm_rx_empty", rx_empty, 1);
        check_val("frm_no_par", parity_err, 0);
        pulse_clear();
        check_val("frm_err_cleared", framing_err, 0);

        // 17 frames with no reads; lowering the divisor may wrap through all-ones first
        baud_div = 11'd1;
        cycles(2100);
        for (int i = 0; i < 17; i++) begin
            d = 8'($urandom_range(0, 255));
            if (i < 16) rx_exp_q.push_back(d);
            send_rx(d, 0, 1'b0, 0);
            if (i == 15) begin
                check_val("ovr_full_at16", rx_full, 1);
                check_val("ovr_none_at16", overrun_err, 0);
            end
        end
        check_val("ovr_set", overrun_err, 1);
        check_val("ovr_still_full", rx_full, 1);
        for (int i = 0; i < 16; i++) read_check();
        check_val("ovr_drained", rx_empty, 1);
        pulse_clear();
        check_val("ovr_cleared", overrun_err, 0);

        // one-clock low glitch
        baud_div = 11'd3;
        cycles(20);
        rx_drv = 1'b0; cycles(1); rx_drv = 1'b1;
        cycles(300);
        check_val("glitch_rx_empty", rx_empty, 1);
        check_val("glitch_flags", {overrun_err, parity_err, framing_err}, 0);

        // fill TX FIFO, then reset during the start bit
        write_uart = 1'b1;
        for (int i = 0; i < 17; i++) begin
            write_data = 8'(i * 13 + 1);
            @(negedge clk);
        end
        write_uart = 1'b0;
        check_val("txf_full", tx_full, 1);
        cycles(10);
        check_val("rst_mid_tx_low", tx, 0);
        reset_n = 1'b0;
        #1;
        check_val("rst_mid_tx_high", tx, 1);
        check_val("rst_mid_busy", tx_busy, 0);
        check_val("rst_mid_tx_full", tx_full, 0);
        check_val("rst_mid_rx_empty", rx_empty, 1);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(100);
        check_val("rst_tx_fifo_empty", tx_busy, 0);
        queue_tx_frame(8'hC3, 0, 0, 1);
        write_word(8'hC3);
        check_tx_frame();
        cycles(100);
        check_val("post_rst_idle", tx_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
